maze_mem_arbiter: RTL and testbench
===================================

# maze_mem_arbiter

Three-requester arbiter for the single-port maze cell RAM that holds the 32x32 wall map. It shares that RAM between the VGA renderer (read-only, latency-critical), the maze generator (read/write) and the player move checker (read-only). It issues at most one RAM command per cycle and routes read data back to the owning requester. It sits between Game_Logic/VGA_Controller and the maze RAM, in the clk domain.

## Interface
- ADDR_W, 10, cell address width (32x32 cells)
- DATA_W, 4, cell word width (wall bits N/E/S/W)
- RAM_LAT, 1, RAM read latency in cycles from ram_en (1..3)
- STARVE_LIMIT, 15, wait cycles before forced grant (used only with MAZE_ARB_STARVE_EN)

One clock; reset is synchronous and active-high.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vga_req / vga_addr  in  1 / ADDR_W  renderer read request
- vga_gnt  out  1  renderer request accepted this cycle
- vga_rvalid / vga_rdata  out  1 / DATA_W  renderer read return
- gen_req / gen_we / gen_addr / gen_wdata  in  1 / 1 / ADDR_W / DATA_W  generator request
- gen_gnt, gen_rvalid  out  1  generator accept / read return valid
- gen_rdata  out  DATA_W  generator read data
- chk_req / chk_addr  in  1 / ADDR_W  move-checker read request
- chk_gnt, chk_rvalid  out  1  checker accept / read return valid
- chk_rdata  out  DATA_W  checker read data
- ram_en, ram_we  out  1  registered RAM command
- ram_addr / ram_wdata  out  ADDR_W / DATA_W  registered RAM command fields
- ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_en
- vga_miss  out  1  pulse: vga_req present but not granted (always 0 without macro)

## Operation
- Handshake: a requester holds req and its fields stable until gnt. A request is accepted in any cycle where req && gnt, and the next request may be presented the following cycle. gnt is combinational from req and internal state.
- Priority: VGA > {gen, chk}. gen and chk are round-robin via the last_lo pointer. last_lo toggles to the granted side whenever gen or chk wins. At reset, gen is favoured.
- Exactly one gnt per cycle at most. No gnt while reset is high.
- Granted command is registered onto ram_* the next cycle. ram_we=1 only for gen writes. ram_en=0 on idle cycles. ram_addr and ram_wdata hold their last values when idle.
- Read tag pipeline (depth RAM_LAT+1) records owner ID (NONE/VGA/GEN/CHK) per accepted read. Writes insert NONE.
- On tag exit: owner rvalid=1 for one cycle, rdata=ram_rdata. Other rdata outputs hold their previous value.
- Ordering: commands execute in grant order. A gen write followed by any read of the same address returns the new data.
- Reset (including mid-transaction): ram_en/ram_we=0; ram_addr, ram_wdata, all rdata=0; all rvalid=0; tag pipeline flushed, so in-flight reads never return. last_lo=chk (gen favoured); starvation counters=0; vga_miss=0.

## Timing
- Request accepted in cycle t, ram_* valid in t+1, rvalid in t+1+RAM_LAT (t+2 at default).
- Throughput: one command per cycle. VGA alone sees back-to-back grants.
- gen/chk worst-case wait without macro: unbounded while vga_req is continuously high. Once VGA is idle, wait is at most 1 cycle (alternation).

## Configuration
- MAZE_ARB_STARVE_EN defined:
  - per-requester wait counters for gen and chk (4 bits at default; sized for STARVE_LIMIT);
  - a counter increments each cycle its req is high and it is not granted, and clears on grant or when req is low;
  - when a counter equals STARVE_LIMIT, that requester is granted over VGA, with round-robin deciding if both are starved;
  - vga_miss pulses in that cycle.
- Undefined: counters absent, VGA strictly first, vga_miss tied 0.

## Structure
- Shared package maze_pkg holds:
  - ADDR_W and DATA_W defaults;
  - wall bit index constants WALL_N/E/S/W;
  - requester ID enum req_id_t {REQ_NONE, REQ_VGA, REQ_GEN, REQ_CHK}.
- Sub-module maze_rr_picker: two-way round-robin picker with last_lo state. Instantiated once for gen/chk.

## Test plan
- VGA-only reads of addr 0..3 back-to-back: vga_gnt high 4 cycles, ram_addr 0,1,2,3 on t+1..t+4, vga_rvalid on t+2..t+5 with the preloaded words.
- gen and chk both requesting continuously, VGA idle: grants alternate gen, chk, gen, … starting with gen after reset.
- gen writes 4'hA to addr 37 and chk reads addr 37 the next cycle: chk_rdata=4'hA, and gen_rvalid never asserts.
- All three request in the same cycle: vga_gnt only. gen is granted once VGA drops. Returns go to the correct owners with no cross-delivery.
- Reset asserted with two reads in flight: no rvalid afterwards, ram_en=0, all outputs at reset values the cycle after reset.
- Starvation: with MAZE_ARB_STARVE_EN, vga_req held high and chk_req high: chk_gnt asserts on wait cycle 15 with vga_miss=1 that cycle. Without the macro, chk_gnt stays 0 throughout.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze cell RAM arbiter: default widths, wall bit
// positions inside a cell word and the requester identifiers used to tag reads.
package maze_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;

  localparam int WALL_N = 0;
  localparam int WALL_E = 1;
  localparam int WALL_S = 2;
  localparam int WALL_W = 3;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_VGA  = 2'd1,
    REQ_GEN  = 2'd2,
    REQ_CHK  = 2'd3
  } req_id_t;

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Bundle of the three requester handshakes plus the RAM command/return bus.
// The slave modport is the arbiter's view; master is the requesters-plus-RAM side.
interface maze_mem_arbiter_if;

  logic                        vga_req;
  logic [maze_pkg::ADDR_W-1:0] vga_addr;
  logic                        vga_gnt;
  logic                        vga_rvalid;
  logic [maze_pkg::DATA_W-1:0] vga_rdata;
  logic                        vga_miss;

  logic                        gen_req;
  logic                        gen_we;
  logic [maze_pkg::ADDR_W-1:0] gen_addr;
  logic [maze_pkg::DATA_W-1:0] gen_wdata;
  logic                        gen_gnt;
  logic                        gen_rvalid;
  logic [maze_pkg::DATA_W-1:0] gen_rdata;

  logic                        chk_req;
  logic [maze_pkg::ADDR_W-1:0] chk_addr;
  logic                        chk_gnt;
  logic                        chk_rvalid;
  logic [maze_pkg::DATA_W-1:0] chk_rdata;

  logic                        ram_en;
  logic                        ram_we;
  logic [maze_pkg::ADDR_W-1:0] ram_addr;
  logic [maze_pkg::DATA_W-1:0] ram_wdata;
  logic [maze_pkg::DATA_W-1:0] ram_rdata;

  modport slave (
    input  vga_req, vga_addr,
    input  gen_req, gen_we, gen_addr, gen_wdata,
    input  chk_req, chk_addr,
    input  ram_rdata,
    output vga_gnt, vga_rvalid, vga_rdata, vga_miss,
    output gen_gnt, gen_rvalid, gen_rdata,
    output chk_gnt, chk_rvalid, chk_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vga_req, vga_addr,
    output gen_req, gen_we, gen_addr, gen_wdata,
    output chk_req, chk_addr,
    output ram_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata, vga_miss,
    input  gen_gnt, gen_rvalid, gen_rdata,
    input  chk_gnt, chk_rvalid, chk_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/maze_rr_picker.sv
// Two-way round-robin picker between the maze generator and the move checker.
// last_lo remembers which of the two was granted most recently; the other one
// wins a tie. Out of reset last_lo points at the checker so the generator wins first.
module maze_rr_picker
  import maze_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_gen,
  input  logic req_chk,
  input  logic take_gen,
  input  logic take_chk,
  output logic pick_gen,
  output logic pick_chk
);

  req_id_t last_lo_q, last_lo_d;

  // Choose the requester that did not win last time when both are asking
  always_comb begin
    pick_gen = req_gen && (!req_chk || (last_lo_q == REQ_CHK));
    pick_chk = req_chk && (!req_gen || (last_lo_q == REQ_GEN));
  end

  // Point last_lo at whichever side actually received the grant this cycle
  always_comb begin
    last_lo_d = last_lo_q;
    if (take_gen) begin
      last_lo_d = REQ_GEN;
    end else if (take_chk) begin
      last_lo_d = REQ_CHK;
    end
  end

  // Pointer register, cleared so the generator is favoured after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      last_lo_q <= REQ_CHK;
    end else begin
      last_lo_q <= last_lo_d;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbiter for the single-port maze cell RAM shared by the VGA renderer, the
// maze generator and the player move checker. VGA has priority; generator and
// checker alternate. Granted commands are registered onto the RAM bus and a
// tag pipeline routes each read return to its owner RAM_LAT+1 cycles later.
// Optional anti-starvation forcing is enabled by defining MAZE_ARB_STARVE_EN.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int RAM_LAT = 1
`ifdef MAZE_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 15
`endif
) (
  input  logic               clk,
  input  logic               reset,
  maze_mem_arbiter_if.slave  bus
);

  logic pick_gen, pick_chk;
  logic vga_gnt, gen_gnt, chk_gnt, vga_miss;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  req_id_t new_tag;
  req_id_t tag_q [RAM_LAT+1];
  req_id_t tag_d [RAM_LAT+1];

  logic              vga_rvalid, gen_rvalid, chk_rvalid;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic [DATA_W-1:0] gen_rdata_q, gen_rdata_d;
  logic [DATA_W-1:0] chk_rdata_q, chk_rdata_d;

  maze_rr_picker u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_gen  (bus.gen_req),
    .req_chk  (bus.chk_req),
    .take_gen (gen_gnt),
    .take_chk (chk_gnt),
    .pick_gen (pick_gen),
    .pick_chk (pick_chk)
  );

`ifdef MAZE_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] gen_wait_q, gen_wait_d;
  logic [CNT_W-1:0] chk_wait_q, chk_wait_d;
  logic             gen_starved, chk_starved;

  // A requester is starved once it has waited exactly LIMIT cycles
  always_comb begin
    gen_starved = bus.gen_req && (gen_wait_q == LIMIT);
    chk_starved = bus.chk_req && (chk_wait_q == LIMIT);
  end

  // Count waiting cycles, saturating at LIMIT and clearing on grant or idle
  always_comb begin
    gen_wait_d = '0;
    chk_wait_d = '0;
    if (bus.gen_req && !gen_gnt) begin
      gen_wait_d = (gen_wait_q == LIMIT) ? gen_wait_q : gen_wait_q + 1'b1;
    end
    if (bus.chk_req && !chk_gnt) begin
      chk_wait_d = (chk_wait_q == LIMIT) ? chk_wait_q : chk_wait_q + 1'b1;
    end
  end

  // Wait counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_wait_q <= '0;
      chk_wait_q <= '0;
    end else begin
      gen_wait_q <= gen_wait_d;
      chk_wait_q <= chk_wait_d;
    end
  end
`endif

  // Grant decision: starved low requesters (if enabled), then VGA, then round-robin
  always_comb begin
    vga_gnt  = 1'b0;
    gen_gnt  = 1'b0;
    chk_gnt  = 1'b0;
    vga_miss = 1'b0;
    if (!reset) begin
`ifdef MAZE_ARB_STARVE_EN
      if (gen_starved || chk_starved) begin
        if (gen_starved && chk_starved) begin
          gen_gnt = pick_gen;
          chk_gnt = pick_chk;
        end else begin
          gen_gnt = gen_starved;
          chk_gnt = chk_starved;
        end
        vga_miss = bus.vga_req;
      end else
`endif
      if (bus.vga_req) begin
        vga_gnt = 1'b1;
      end else begin
        gen_gnt = pick_gen;
        chk_gnt = pick_chk;
      end
    end
  end

  // Build the next RAM command and the owner tag for the granted request
  always_comb begin
    ram_en_d    = vga_gnt || gen_gnt || chk_gnt;
    ram_we_d    = gen_gnt && bus.gen_we;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    new_tag     = REQ_NONE;
    if (vga_gnt) begin
      ram_addr_d = bus.vga_addr;
      new_tag    = REQ_VGA;
    end else if (gen_gnt) begin
      ram_addr_d = bus.gen_addr;
      if (bus.gen_we) begin
        ram_wdata_d = bus.gen_wdata;
      end else begin
        new_tag = REQ_GEN;
      end
    end else if (chk_gnt) begin
      ram_addr_d = bus.chk_addr;
      new_tag    = REQ_CHK;
    end
  end

  // Shift the owner tags so the last stage lines up with ram_rdata
  always_comb begin
    tag_d[0] = new_tag;
    for (int i = 1; i <= RAM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Deliver read data to the tagged owner; other owners keep their last word
  always_comb begin
    vga_rvalid  = !reset && (tag_q[RAM_LAT] == REQ_VGA);
    gen_rvalid  = !reset && (tag_q[RAM_LAT] == REQ_GEN);
    chk_rvalid  = !reset && (tag_q[RAM_LAT] == REQ_CHK);
    vga_rdata_d = vga_rvalid ? bus.ram_rdata : vga_rdata_q;
    gen_rdata_d = gen_rvalid ? bus.ram_rdata : gen_rdata_q;
    chk_rdata_d = chk_rvalid ? bus.ram_rdata : chk_rdata_q;
  end

  // Command, tag pipeline and read-data hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      vga_rdata_q <= '0;
      gen_rdata_q <= '0;
      chk_rdata_q <= '0;
      for (int i = 0; i <= RAM_LAT; i++) begin
        tag_q[i] <= REQ_NONE;
      end
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      vga_rdata_q <= vga_rdata_d;
      gen_rdata_q <= gen_rdata_d;
      chk_rdata_q <= chk_rdata_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.vga_gnt    = vga_gnt;
  assign bus.gen_gnt    = gen_gnt;
  assign bus.chk_gnt    = chk_gnt;
  assign bus.vga_miss   = vga_miss;
  assign bus.vga_rvalid = vga_rvalid;
  assign bus.gen_rvalid = gen_rvalid;
  assign bus.chk_rvalid = chk_rvalid;
  assign bus.vga_rdata  = vga_rdata_d;
  assign bus.gen_rdata  = gen_rdata_d;
  assign bus.chk_rdata  = chk_rdata_d;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed testbench for maze_mem_arbiter with a one-cycle-latency RAM model.
// Starvation expectations follow MAZE_ARB_STARVE_EN when it is defined.
module tb_maze_mem_arbiter;
  import maze_pkg::*;

`ifdef MAZE_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   passed;
  int   total;

  maze_mem_arbiter_if bus ();

  maze_mem_arbiter #(.RAM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: write on ram_en&&ram_we, read data available one cycle after ram_en
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            rd_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = rd_q;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.gen_req   = 1'b0;
    bus.gen_we    = 1'b0;
    bus.gen_addr  = '0;
    bus.gen_wdata = '0;
    bus.chk_req   = 1'b0;
    bus.chk_addr  = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    bus.vga_req = 1'b1;
    bus.gen_req = 1'b1;
    next_cycle();
    @(negedge clk);
    total++; if (bus.vga_gnt !== 1'b0 || bus.gen_gnt !== 1'b0) $display("[TB] FAIL reset_gnt: vga %b gen %b want 0 0", bus.vga_gnt, bus.gen_gnt); else passed++;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++; if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) $display("[TB] FAIL reset_ram_cmd: en %b we %b want 0 0", bus.ram_en, bus.ram_we); else passed++;
    total++; if (bus.ram_addr !== '0 || bus.ram_wdata !== '0) $display("[TB] FAIL reset_ram_fields: addr %0d wdata %h want 0 0", bus.ram_addr, bus.ram_wdata); else passed++;
    total++; if ({bus.vga_rvalid, bus.gen_rvalid, bus.chk_rvalid, bus.vga_miss} !== 4'b0) $display("[TB] FAIL reset_flags: got %b want 0000", {bus.vga_rvalid, bus.gen_rvalid, bus.chk_rvalid, bus.vga_miss}); else passed++;
    total++; if ({bus.vga_rdata, bus.gen_rdata, bus.chk_rdata} !== 12'h000) $display("[TB] FAIL reset_rdata: got %h want 000", {bus.vga_rdata, bus.gen_rdata, bus.chk_rdata}); else passed++;
    next_cycle();
  endtask

  task automatic test_vga_burst;
    logic [DATA_W-1:0] exp_word [4];
    exp_word[0] = 4'h9; exp_word[1] = 4'h3; exp_word[2] = 4'h6; exp_word[3] = 4'hC;
    for (int k = 0; k < 6; k++) begin
      bus.vga_req  = (k < 4);
      bus.vga_addr = ADDR_W'(k < 4 ? k : 0);
      @(negedge clk);
      total++; if (bus.vga_gnt !== (k < 4)) $display("[TB] FAIL vga_burst_gnt c%0d: got %b want %b", k, bus.vga_gnt, (k < 4)); else passed++;
      if (k >= 1 && k <= 4) begin
        total++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== ADDR_W'(k - 1)) $display("[TB] FAIL vga_burst_ram c%0d: en %b addr %0d want 1 %0d", k, bus.ram_en, bus.ram_addr, k - 1); else passed++;
      end
      total++; if (bus.vga_rvalid !== (k >= 2)) $display("[TB] FAIL vga_burst_rvalid c%0d: got %b want %b", k, bus.vga_rvalid, (k >= 2)); else passed++;
      if (k >= 2) begin
        total++; if (bus.vga_rdata !== exp_word[k-2]) $display("[TB] FAIL vga_burst_rdata c%0d: got %h want %h", k, bus.vga_rdata, exp_word[k-2]); else passed++;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_round_robin;
    do_reset();
    bus.gen_req = 1'b1; bus.gen_we = 1'b0; bus.gen_addr = 10'd5;
    bus.chk_req = 1'b1; bus.chk_addr = 10'd6;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (bus.gen_gnt !== (k % 2 == 0) || bus.chk_gnt !== (k % 2 == 1)) $display("[TB] FAIL rr_alternate c%0d: gen %b chk %b want %b %b", k, bus.gen_gnt, bus.chk_gnt, (k % 2 == 0), (k % 2 == 1)); else passed++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_write_then_read;
    logic gen_rv_seen;
    gen_rv_seen = 1'b0;
    bus.gen_req = 1'b1; bus.gen_we = 1'b1; bus.gen_addr = 10'd37; bus.gen_wdata = 4'hA;
    @(negedge clk);
    gen_rv_seen |= bus.gen_rvalid;
    total++; if (bus.gen_gnt !== 1'b1) $display("[TB] FAIL wr_gen_gnt: got %b want 1", bus.gen_gnt); else passed++;
    next_cycle();
    idle_inputs();
    bus.chk_req = 1'b1; bus.chk_addr = 10'd37;
    @(negedge clk);
    gen_rv_seen |= bus.gen_rvalid;
    total++; if (bus.chk_gnt !== 1'b1) $display("[TB] FAIL wr_chk_gnt: got %b want 1", bus.chk_gnt); else passed++;
    total++; if ({bus.ram_en, bus.ram_we} !== 2'b11 || bus.ram_addr !== 10'd37 || bus.ram_wdata !== 4'hA) $display("[TB] FAIL wr_ram_cmd: en %b we %b addr %0d wdata %h want 1 1 37 a", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata); else passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    gen_rv_seen |= bus.gen_rvalid;
    total++; if ({bus.ram_en, bus.ram_we} !== 2'b10 || bus.ram_addr !== 10'd37) $display("[TB] FAIL rd_ram_cmd: en %b we %b addr %0d want 1 0 37", bus.ram_en, bus.ram_we, bus.ram_addr); else passed++;
    next_cycle();
    @(negedge clk);
    gen_rv_seen |= bus.gen_rvalid;
    total++; if (bus.chk_rvalid !== 1'b1 || bus.chk_rdata !== 4'hA) $display("[TB] FAIL wr_rd_data: rvalid %b rdata %h want 1 a", bus.chk_rvalid, bus.chk_rdata); else passed++;
    next_cycle();
    @(negedge clk);
    gen_rv_seen |= bus.gen_rvalid;
    total++; if (gen_rv_seen !== 1'b0) $display("[TB] FAIL wr_no_gen_rvalid: got %b want 0", gen_rv_seen); else passed++;
    next_cycle();
  endtask

  task automatic test_all_three;
    bus.vga_req = 1'b1; bus.vga_addr = 10'd1;
    bus.gen_req = 1'b1; bus.gen_we = 1'b0; bus.gen_addr = 10'd2;
    bus.chk_req = 1'b1; bus.chk_addr = 10'd3;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) bus.vga_req = 1'b0;
      if (k == 2) bus.gen_req = 1'b0;
      if (k == 3) bus.chk_req = 1'b0;
      @(negedge clk);
      total++; if ({bus.vga_gnt, bus.gen_gnt, bus.chk_gnt} !== {k == 0, k == 1, k == 2}) $display("[TB] FAIL all3_gnt c%0d: got %b want %b", k, {bus.vga_gnt, bus.gen_gnt, bus.chk_gnt}, {k == 0, k == 1, k == 2}); else passed++;
      total++; if ({bus.vga_rvalid, bus.gen_rvalid, bus.chk_rvalid} !== {k == 2, k == 3, k == 4}) $display("[TB] FAIL all3_rvalid c%0d: got %b want %b", k, {bus.vga_rvalid, bus.gen_rvalid, bus.chk_rvalid}, {k == 2, k == 3, k == 4}); else passed++;
      if (k == 5) begin
        total++; if ({bus.vga_rdata, bus.gen_rdata, bus.chk_rdata} !== 12'h36C) $display("[TB] FAIL all3_rdata: got %h want 36c", {bus.vga_rdata, bus.gen_rdata, bus.chk_rdata}); else passed++;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight;
    bus.vga_req = 1'b1; bus.vga_addr = 10'd0;
    next_cycle();
    bus.vga_addr = 10'd1;
    next_cycle();
    reset = 1'b1;
    bus.vga_addr = 10'd2;
    @(negedge clk);
    total++; if (bus.vga_gnt !== 1'b0 || bus.vga_rvalid !== 1'b0) $display("[TB] FAIL rst_fly_during: gnt %b rvalid %b want 0 0", bus.vga_gnt, bus.vga_rvalid); else passed++;
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++; if ({bus.ram_en, bus.ram_we} !== 2'b00 || bus.ram_addr !== '0 || bus.ram_wdata !== '0) $display("[TB] FAIL rst_fly_ram: en %b we %b addr %0d wdata %h want 0 0 0 0", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata); else passed++;
    total++; if ({bus.vga_rdata, bus.gen_rdata, bus.chk_rdata} !== 12'h000) $display("[TB] FAIL rst_fly_rdata: got %h want 000", {bus.vga_rdata, bus.gen_rdata, bus.chk_rdata}); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({bus.vga_rvalid, bus.gen_rvalid, bus.chk_rvalid} !== 3'b000) $display("[TB] FAIL rst_fly_rvalid c%0d: got %b want 000", k, {bus.vga_rvalid, bus.gen_rvalid, bus.chk_rvalid}); else passed++;
      next_cycle();
    end
  endtask

  task automatic test_starvation;
    logic exp_chk;
    do_reset();
    bus.vga_req = 1'b1; bus.vga_addr = 10'd0;
    bus.chk_addr = 10'd4;
    for (int k = 0; k < 20; k++) begin
      bus.chk_req = STARVE_ON ? (k <= 15) : 1'b1;
      exp_chk = STARVE_ON && (k == 15);
      @(negedge clk);
      total++; if ({bus.vga_gnt, bus.chk_gnt, bus.vga_miss} !== {!exp_chk, exp_chk, exp_chk}) $display("[TB] FAIL starve c%0d: vga %b chk %b miss %b want %b %b %b", k, bus.vga_gnt, bus.chk_gnt, bus.vga_miss, !exp_chk, exp_chk, exp_chk); else passed++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  // Run every scenario in order, then print the summary
  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    idle_inputs();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = (4'b0001 << WALL_N) | (4'b0001 << WALL_W);
    mem[1] = (4'b0001 << WALL_N) | (4'b0001 << WALL_E);
    mem[2] = (4'b0001 << WALL_E) | (4'b0001 << WALL_S);
    mem[3] = (4'b0001 << WALL_S) | (4'b0001 << WALL_W);
    rd_q = '0;
    #1;
    test_reset();
    test_vga_burst();
    test_round_robin();
    test_write_then_read();
    test_all_three();
    test_reset_inflight();
    test_starvation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
